// File: rtl/me_pkg.sv
// Constants, state encoding and result record shared by the motion-estimator block loader.
package me_pkg;

  localparam int R_SIZE     = 256;
  localparam int S_SIZE     = 1024;
  localparam int RUN_CYCLES = 4112;
  localparam int R_AW       = 8;
  localparam int S_AW       = 10;
  localparam int CNT_W      = 13;
  localparam int TAG_W      = 16;

  typedef enum logic [1:0] {
    LOAD_R  = 2'd0,
    LOAD_S  = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] bestdist;
    logic [3:0] mvx;
    logic [3:0] mvy;
    logic       timeout;
  } result_t;

  // The top reports "no match" with an all-ones distance.
  function automatic logic is_notfound(input logic [7:0] bestdist);
    return (bestdist == 8'hFF);
  endfunction

endpackage

// File: rtl/me_block_loader_if.sv
// Byte stream, memory write, estimator control and result bus of the block loader.
// With ME_BLKCNT_EN defined the bus also carries the 16-bit result tag.
interface me_block_loader_if;
  import me_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             r_we;
  logic [R_AW-1:0]  r_waddr;
  logic [7:0]       r_wdata;
  logic             s_we;
  logic [S_AW-1:0]  s_waddr;
  logic [7:0]       s_wdata;
  logic             me_start;
  logic             me_completed;
  logic [7:0]       me_bestdist;
  logic [3:0]       me_motionx;
  logic [3:0]       me_motiony;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_bestdist;
  logic [3:0]       res_mvx;
  logic [3:0]       res_mvy;
  logic             res_notfound;
  logic             res_timeout;
`ifdef ME_BLKCNT_EN
  logic [TAG_W-1:0] res_tag;
`endif

  modport slave (
`ifdef ME_BLKCNT_EN
    output res_tag,
`endif
    input  in_valid, in_data, me_completed, me_bestdist, me_motionx, me_motiony, res_ready,
    output in_ready, r_we, r_waddr, r_wdata, s_we, s_waddr, s_wdata, me_start,
    output res_valid, res_bestdist, res_mvx, res_mvy, res_notfound, res_timeout
  );

  modport master (
`ifdef ME_BLKCNT_EN
    input  res_tag,
`endif
    output in_valid, in_data, me_completed, me_bestdist, me_motionx, me_motiony, res_ready,
    input  in_ready, r_we, r_waddr, r_wdata, s_we, s_waddr, s_wdata, me_start,
    input  res_valid, res_bestdist, res_mvx, res_mvy, res_notfound, res_timeout
  );

endinterface

// File: rtl/me_result_slot.sv
// One-entry valid/ready holding register; a load in the same cycle as a take wins.
module me_result_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         take_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next slot contents: reload has priority over the consumer taking the entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && take_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/me_block_loader.sv
// Streams reference and search bytes into the R/S memories, runs the estimator and queues its result.
// Optional ME_BLKCNT_EN adds a per-block 16-bit result tag.
module me_block_loader
  import me_pkg::*;
(
  input logic          clock,
  input logic          reset_n,
  me_block_loader_if.slave bus
);

`ifdef ME_BLKCNT_EN
  localparam int PAY_W = $bits(result_t) + 1 + TAG_W;
`else
  localparam int PAY_W = $bits(result_t) + 1;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             timeout_q, timeout_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             slot_load_s;
  result_t          cap_res_s;
  result_t          out_res_s;
  logic [PAY_W-1:0] payload_s;
  logic [PAY_W-1:0] slot_data_s;
`ifdef ME_BLKCNT_EN
  logic [TAG_W-1:0] blk_cnt_q;
  logic [TAG_W-1:0] run_tag_q;
`endif

  // Gating with reset_n keeps in_ready and the write strobes low while reset is held.
  assign in_ready_s = reset_n & ((state_q == LOAD_R) || (state_q == LOAD_S));
  assign accept_s   = bus.in_valid & in_ready_s;

  // Sequencer next-state, counter and timeout flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    slot_load_s = 1'b0;
    case (state_q)
      LOAD_R: begin
        if (accept_s && (cnt_q == CNT_W'(R_SIZE - 1))) begin
          state_d = LOAD_S;
          cnt_d   = {CNT_W{1'b0}};
        end else if (accept_s) begin
          cnt_d = cnt_q + 13'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD_S: begin
        if (accept_s && (cnt_q == CNT_W'(S_SIZE - 1))) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else if (accept_s) begin
          cnt_d = cnt_q + 13'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        // A completed seen in the first RUN cycle belongs to the previous block.
        if (bus.me_completed && (cnt_q != 13'd0)) begin
          state_d   = CAPTURE;
          cnt_d     = {CNT_W{1'b0}};
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
          state_d   = CAPTURE;
          cnt_d     = {CNT_W{1'b0}};
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      CAPTURE: begin
        if (bus.res_valid && !bus.res_ready) begin
          state_d = CAPTURE;
        end else begin
          slot_load_s = 1'b1;
          state_d     = LOAD_R;
          cnt_d       = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_d = LOAD_R;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign start_d = (state_d == RUN);

  // Sequencer registers; start is registered so it drops asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LOAD_R;
      cnt_q     <= {CNT_W{1'b0}};
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ME_BLKCNT_EN
  // Block index: the running block keeps the pre-increment value as its tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_q <= {TAG_W{1'b0}};
      run_tag_q <= {TAG_W{1'b0}};
    end else if ((state_q == LOAD_S) && (state_d == RUN)) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
      run_tag_q <= blk_cnt_q;
    end else begin
      blk_cnt_q <= blk_cnt_q;
      run_tag_q <= run_tag_q;
    end
  end
`endif

  assign cap_res_s.bestdist = bus.me_bestdist;
  assign cap_res_s.mvx      = bus.me_motionx;
  assign cap_res_s.mvy      = bus.me_motiony;
  assign cap_res_s.timeout  = timeout_q;

`ifdef ME_BLKCNT_EN
  assign payload_s = {cap_res_s, is_notfound(bus.me_bestdist), run_tag_q};
`else
  assign payload_s = {cap_res_s, is_notfound(bus.me_bestdist)};
`endif

  me_result_slot #(
    .W (PAY_W)
  ) u_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (slot_load_s),
    .data_i  (payload_s),
    .take_i  (bus.res_ready),
    .valid_o (bus.res_valid),
    .data_o  (slot_data_s)
  );

`ifdef ME_BLKCNT_EN
  assign {out_res_s, bus.res_notfound, bus.res_tag} = slot_data_s;
`else
  assign {out_res_s, bus.res_notfound} = slot_data_s;
`endif

  assign bus.res_bestdist = out_res_s.bestdist;
  assign bus.res_mvx      = out_res_s.mvx;
  assign bus.res_mvy      = out_res_s.mvy;
  assign bus.res_timeout  = out_res_s.timeout;

  assign bus.in_ready = in_ready_s;
  assign bus.me_start = start_q;
  assign bus.r_we     = accept_s & (state_q == LOAD_R);
  assign bus.r_waddr  = cnt_q[R_AW-1:0];
  assign bus.r_wdata  = bus.r_we ? bus.in_data : 8'd0;
  assign bus.s_we     = accept_s & (state_q == LOAD_S);
  assign bus.s_waddr  = cnt_q[S_AW-1:0];
  assign bus.s_wdata  = bus.s_we ? bus.in_data : 8'd0;

endmodule

// File: tb/tb_me_block_loader.sv
// Directed bench for me_block_loader: streaming, run/timeout, result back-pressure, async reset.
module tb_me_block_loader;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   n_run;
  logic [7:0] rf [256];
  logic [7:0] sw [1024];
  logic [7:0] r_mem [256];
  logic [7:0] s_mem [1024];

  me_block_loader_if bus ();

  me_block_loader dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models fed by the loader's write ports.
  always @(posedge clock) begin
    if (bus.r_we) r_mem[bus.r_waddr] <= bus.r_wdata;
    if (bus.s_we) s_mem[bus.s_waddr] <= bus.s_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Random search window; reference is the 16x16 patch at (-3,+5) from the centre.
  task automatic gen_data();
    for (int i = 0; i < 1024; i++) sw[i] = 8'($urandom);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        rf[y*16 + x] = sw[(y + 13)*32 + (x + 5)];
  endtask

  task automatic stream_n(input int n, input bit chk);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = (k < 256) ? rf[k] : sw[k - 256];
      @(negedge clock);
      if (chk) begin
        check_val("in_ready_load", bus.in_ready, 32'd1);
        if (k < 256) begin
          check_val("r_we", bus.r_we, 32'd1);
          check_val("r_waddr", bus.r_waddr, k);
          check_val("s_we_in_r", bus.s_we, 32'd0);
        end else begin
          check_val("s_we", bus.s_we, 32'd1);
          check_val("s_waddr", bus.s_waddr, k - 256);
          check_val("r_we_in_s", bus.r_we, 32'd0);
        end
      end
    end
  endtask

  task automatic full_block(input bit chk);
    gen_data();
    stream_n(1280, chk);
    check_val("start_before_run", bus.me_start, 32'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check_val("start_rise", bus.me_start, 32'd1);
    check_val("in_ready_run", bus.in_ready, 32'd0);
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (r_mem[i] !== rf[i]) bad++;
    for (int i = 0; i < 1024; i++) if (s_mem[i] !== sw[i]) bad++;
    check_val(tag, bad, 32'd0);
  endtask

  // Emulates the estimator: completes while RUN cnt == delay (delay 0 = never).
  task automatic run_top(input int delay, input logic [7:0] bd, input logic [3:0] mx,
                         input logic [3:0] my, output int n);
    n = 1;
    for (int c = 1; c < 5000; c++) begin
      @(posedge clock); #1;
      if (c == 1) bus.me_completed = 1'b0;
      if (c == ((delay == 0) ? 1 : delay)) begin
        bus.me_completed = (delay != 0);
        bus.me_bestdist  = bd;
        bus.me_motionx   = mx;
        bus.me_motiony   = my;
      end
      @(negedge clock);
      if (!bus.me_start) break;
      n++;
    end
    check_val("run_ended", bus.me_start, 32'd0);
    check_val("in_ready_capture", bus.in_ready, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] bd, input logic [3:0] mx,
                              input logic [3:0] my, input logic to, input logic [15:0] tg);
    check_val({tag, "_valid"}, bus.res_valid, 32'd1);
    check_val({tag, "_bestdist"}, bus.res_bestdist, bd);
    check_val({tag, "_mvx"}, bus.res_mvx, mx);
    check_val({tag, "_mvy"}, bus.res_mvy, my);
    check_val({tag, "_timeout"}, bus.res_timeout, to);
    check_val({tag, "_notfound"}, bus.res_notfound, (bd == 8'hFF) ? 32'd1 : 32'd0);
`ifdef ME_BLKCNT_EN
    check_val({tag, "_tag"}, bus.res_tag, tg);
`else
    if (tg != 16'd0) begin end
`endif
  endtask

  task automatic take_result();
    @(posedge clock); #1;
    bus.res_ready = 1'b1;
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    @(negedge clock);
    check_val("res_taken", bus.res_valid, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.me_completed = 1'b0;
    bus.me_bestdist = 8'd0;
    bus.me_motionx = 4'd0;
    bus.me_motiony = 4'd0;
    bus.res_ready = 1'b0;
    #3;
    check_val("rst_start", bus.me_start, 32'd0);
    check_val("rst_in_ready", bus.in_ready, 32'd0);
    check_val("rst_res_valid", bus.res_valid, 32'd0);
    check_val("rst_r_we", bus.r_we, 32'd0);
    check_val("rst_s_we", bus.s_we, 32'd0);
    check_val("rst_res_bestdist", bus.res_bestdist, 32'd0);
    #19 reset_n = 1'b1;
    @(negedge clock);
    check_val("in_ready_after_rst", bus.in_ready, 32'd1);

    // Block 0: exact match at (-3,+5).
    full_block(1'b1);
    check_mem("mem_block0");
    run_top(20, 8'd0, 4'hD, 4'h5, n_run);
    check_val("run_len_b0", n_run, 32'd21);
    @(negedge clock);
    check_result("b0", 8'd0, 4'hD, 4'h5, 1'b0, 16'd0);
    check_val("in_ready_next", bus.in_ready, 32'd1);
    take_result();

    // Block 1: never completes (stale completed at cnt 0 must be ignored) -> timeout.
    full_block(1'b0);
    run_top(0, 8'hFF, 4'h0, 4'h0, n_run);
    check_val("run_len_timeout", n_run, 32'd4112);
    @(negedge clock);
    check_result("b1", 8'hFF, 4'h0, 4'h0, 1'b1, 16'd1);
    take_result();

    // Block 2: completed on the last budget cycle -> completed wins.
    full_block(1'b0);
    run_top(4111, 8'h07, 4'h8, 4'h7, n_run);
    check_val("run_len_tie", n_run, 32'd4112);
    @(negedge clock);
    check_result("b2", 8'h07, 4'h8, 4'h7, 1'b0, 16'd2);
    take_result();

    // Blocks 3/4: result back-pressure across two blocks.
    full_block(1'b0);
    run_top(30, 8'h11, 4'h2, 4'hE, n_run);
    @(negedge clock);
    check_result("b3", 8'h11, 4'h2, 4'hE, 1'b0, 16'd3);
    full_block(1'b1);
    check_val("hold_during_load", bus.res_bestdist, 32'h11);
    run_top(40, 8'h22, 4'h7, 4'h8, n_run);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("stall_start", bus.me_start, 32'd0);
      check_val("stall_in_ready", bus.in_ready, 32'd0);
      check_val("stall_hold", bus.res_bestdist, 32'h11);
    end
    @(posedge clock); #1;
    bus.res_ready = 1'b1;
    @(negedge clock);
    check_val("pre_swap_hold", bus.res_bestdist, 32'h11);
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    @(negedge clock);
    check_result("b4", 8'h22, 4'h7, 4'h8, 1'b0, 16'd4);
    check_val("in_ready_after_swap", bus.in_ready, 32'd1);
    take_result();

    // Reset in the middle of LOAD_S at cnt 500.
    gen_data();
    stream_n(756, 1'b0);
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_data = sw[500];
    #2;
    check_val("mid_s_we", bus.s_we, 32'd1);
    check_val("mid_s_waddr", bus.s_waddr, 32'd500);
    reset_n = 1'b0;
    #1;
    check_val("rstS_s_we", bus.s_we, 32'd0);
    check_val("rstS_r_we", bus.r_we, 32'd0);
    check_val("rstS_start", bus.me_start, 32'd0);
    check_val("rstS_res_valid", bus.res_valid, 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    full_block(1'b1);
    check_mem("mem_after_rst");
    run_top(10, 8'h33, 4'h1, 4'hF, n_run);
    @(negedge clock);
    check_result("b5", 8'h33, 4'h1, 4'hF, 1'b0, 16'd0);

    // Reset in the middle of RUN with a result waiting.
    full_block(1'b0);
    bus.me_completed = 1'b0;
    repeat (100) @(posedge clock);
    @(negedge clock);
    check_val("pre_rst_valid", bus.res_valid, 32'd1);
    check_val("pre_rst_start", bus.me_start, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("rstR_start", bus.me_start, 32'd0);
    check_val("rstR_res_valid", bus.res_valid, 32'd0);
    check_val("rstR_in_ready", bus.in_ready, 32'd0);
    check_val("rstR_r_we", bus.r_we, 32'd0);
    check_val("rstR_s_we", bus.s_we, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    full_block(1'b1);
    run_top(5, 8'h44, 4'h0, 4'h0, n_run);
    check_val("run_len_b6", n_run, 32'd6);
    @(negedge clock);
    check_result("b6", 8'h44, 4'h0, 4'h0, 1'b0, 16'd0);
    take_result();

`ifdef ME_BLKCNT_EN
    // Tag wrap: counter preset to FFFF.
    force dut.blk_cnt_q = 16'hFFFF;
    #1;
    release dut.blk_cnt_q;
    full_block(1'b0);
    run_top(5, 8'h55, 4'h3, 4'h3, n_run);
    @(negedge clock);
    check_result("tag_ffff", 8'h55, 4'h3, 4'h3, 1'b0, 16'hFFFF);
    take_result();
    full_block(1'b0);
    run_top(5, 8'h66, 4'h4, 4'h4, n_run);
    @(negedge clock);
    check_result("tag_wrap", 8'h66, 4'h4, 4'h4, 1'b0, 16'h0000);
    take_result();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
